// File: rtl/mac_sequencer.sv
// Forward-pass sequencer: steps an index over N_INPUTS x/w pairs, accumulates
// x*w at full precision, then launches a fixed-latency loss stage and signals completion.
module mac_sequencer #(
   parameter int unsigned N_INPUTS = 8,
   parameter int unsigned LOSS_LAT = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [3:0]                   target_i,
   input  logic [9:0]                   x_i,
   input  logic [7:0]                   w_i,
   output logic [$clog2(N_INPUTS)-1:0]  addr_o,
   output logic                         busy_o,
   output logic [22:0]                  final_o,
   output logic [3:0]                   target_o,
   output logic                         loss_en_o,
   output logic                         done_o
);

   localparam int unsigned AW = $clog2(N_INPUTS);
   localparam int unsigned CW = $clog2(LOSS_LAT + 1);

   typedef enum logic [1:0] {IDLE, MAC, LOSS, DONE} state_t;

   state_t         state;
   logic [22:0]    acc;
   logic [CW-1:0]  loss_cnt;
   logic [17:0]    prod;
   logic [22:0]    sum;

   // addr_o doubles as the MAC index, so x_i/w_i belong to the current addr_o
   assign prod = {8'b0, x_i} * {10'b0, w_i};
   assign sum  = acc + {5'b0, prod};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         acc       <= '0;
         loss_cnt  <= '0;
         addr_o    <= '0;
         busy_o    <= 1'b0;
         final_o   <= '0;
         target_o  <= '0;
         loss_en_o <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         loss_en_o <= 1'b0;
         done_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state    <= MAC;
                  acc      <= '0;
                  addr_o   <= '0;
                  target_o <= target_i;
                  busy_o   <= 1'b1;
               end
            end
            MAC: begin
               if (addr_o == AW'(N_INPUTS - 1)) begin
                  final_o   <= sum;
                  acc       <= '0;
                  addr_o    <= '0;
                  loss_cnt  <= '0;
                  loss_en_o <= 1'b1;
                  state     <= LOSS;
               end else begin
                  acc    <= sum;
                  addr_o <= addr_o + 1'b1;
               end
            end
            LOSS: begin
               if (loss_cnt == CW'(LOSS_LAT - 1)) begin
                  loss_cnt <= '0;
                  done_o   <= 1'b1;
                  state    <= DONE;
               end else begin
                  loss_cnt <= loss_cnt + 1'b1;
               end
            end
            DONE: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: default instance plus a N_INPUTS=4/LOSS_LAT=1 instance,
// with expected dot products queued at start and compared when final_o is loaded.
module tb_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        start4 = 1'b0;
   logic [3:0]  target_i = '0;
   logic [9:0]  x_i, x4;
   logic [7:0]  w_i, w4;
   logic [2:0]  addr_o;
   logic [1:0]  addr4;
   logic        busy_o, busy4, loss_en_o, loss4, done_o, done4;
   logic [22:0] final_o, final4;
   logic [3:0]  target_o, target4;

   logic [9:0]  xmem [8];
   logic [7:0]  wmem [8];
   logic [22:0] sb [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      x_i = xmem[addr_o];
      w_i = wmem[addr_o];
      x4  = xmem[{1'b0, addr4}];
      w4  = wmem[{1'b0, addr4}];
   end

   mac_sequencer dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .target_i(target_i),
      .x_i(x_i), .w_i(w_i), .addr_o(addr_o), .busy_o(busy_o),
      .final_o(final_o), .target_o(target_o), .loss_en_o(loss_en_o), .done_o(done_o)
   );

   mac_sequencer #(.N_INPUTS(4), .LOSS_LAT(1)) dut4 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start4), .target_i(target_i),
      .x_i(x4), .w_i(w4), .addr_o(addr4), .busy_o(busy4),
      .final_o(final4), .target_o(target4), .loss_en_o(loss4), .done_o(done4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_mem(input logic [9:0] xfix, input logic [7:0] wfix, input bit ramp);
      for (int k = 0; k < 8; k++) begin
         xmem[k] = ramp ? 10'(k + 1) : xfix;
         wmem[k] = wfix;
      end
   endtask

   function automatic logic [22:0] model_sum(input int n);
      logic [22:0] s;
      s = '0;
      for (int k = 0; k < n; k++) s += 23'(xmem[k]) * 23'(wmem[k]);
      return s;
   endfunction

   // One default-instance pass, starting from IDLE; prev is final_o before the pass
   task automatic run_pass(input logic [3:0] tgt, input logic [22:0] prev);
      logic [22:0] e;
      sb.push_back(model_sum(8));
      start_i  = 1'b1;
      target_i = tgt;
      tick();
      start_i  = 1'b0;
      target_i = 4'hA;
      for (int k = 0; k < 8; k++) begin
         chk("mac_busy", busy_o, 1);
         chk("mac_addr", addr_o, k);
         chk("mac_final_hold", final_o, prev);
         chk("mac_loss_en", loss_en_o, 0);
         tick();
      end
      e = sb.pop_front();
      chk("loss_en_c9", loss_en_o, 1);
      chk("done_c9", done_o, 0);
      chk("addr_c9", addr_o, 0);
      chk("target", target_o, tgt);
      chk("final_c9", final_o, e);
      tick();
      chk("loss_en_c10", loss_en_o, 0);
      chk("done_c10", done_o, 0);
      chk("busy_c10", busy_o, 1);
      tick();
      chk("done_c11", done_o, 1);
      chk("loss_en_c11", loss_en_o, 0);
      chk("busy_c11", busy_o, 1);
      tick();
      chk("done_c12", done_o, 0);
      chk("busy_c12", busy_o, 0);
      chk("final_c12", final_o, e);
   endtask

   initial begin
      logic [22:0] e;
      set_mem('0, 8'd2, 1'b1);

      // reset with start held high must not start a pass
      rst_i = 1'b1; start_i = 1'b1; target_i = 4'h7;
      tick(); tick();
      chk("rst_busy", busy_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_final", final_o, 0);
      chk("rst_target", target_o, 0);
      chk("rst_loss_en", loss_en_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst4_busy", busy4, 0);
      chk("rst4_final", final4, 0);
      rst_i = 1'b0;
      tick();
      chk("first_start_after_rst", busy_o, 1);
      start_i = 1'b0;
      rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
      chk("rerst_busy", busy_o, 0);

      run_pass(4'd5, 23'd0);

      set_mem('0, 8'd0, 1'b1);
      run_pass(4'd3, 23'd72);

      set_mem(10'd1023, 8'd255, 1'b0);
      run_pass(4'd9, 23'd0);

      // held start: passes every 12 cycles, DONE cycle ignores start
      set_mem('0, 8'd2, 1'b1);
      for (int p = 0; p < 3; p++) sb.push_back(model_sum(8));
      start_i = 1'b1;
      tick();
      for (int c = 1; c <= 36; c++) begin
         chk("held_done", done_o, (c == 11 || c == 23 || c == 35));
         chk("held_loss_en", loss_en_o, (c == 9 || c == 21 || c == 33));
         chk("held_busy", busy_o, (c % 12) != 0);
         if (c == 9 || c == 21 || c == 33) begin
            e = sb.pop_front();
            chk("held_final", final_o, e);
         end
         if (c == 36) start_i = 1'b0;
         tick();
      end
      chk("held_stop", busy_o, 0);

      // reset asserted in cycle 5 of a pass
      start_i = 1'b1; target_i = 4'd6;
      tick();
      start_i = 1'b0;
      tick(); tick(); tick(); tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_final", final_o, 0);
      chk("midrst_addr", addr_o, 0);
      chk("midrst_target", target_o, 0);
      for (int c = 0; c < 14; c++) begin
         chk("midrst_no_loss_en", loss_en_o, 0);
         chk("midrst_no_done", done_o, 0);
         tick();
      end

      // N_INPUTS=4, LOSS_LAT=1 instance
      sb.push_back(model_sum(4));
      start4 = 1'b1; target_i = 4'd12;
      tick();
      start4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("n4_addr", addr4, k);
         chk("n4_busy", busy4, 1);
         chk("n4_loss_en", loss4, 0);
         tick();
      end
      e = sb.pop_front();
      chk("n4_loss_en_c5", loss4, 1);
      chk("n4_done_c5", done4, 0);
      chk("n4_final", final4, e);
      chk("n4_target", target4, 12);
      tick();
      chk("n4_done_c6", done4, 1);
      chk("n4_loss_en_c6", loss4, 0);
      tick();
      chk("n4_done_c7", done4, 0);
      chk("n4_busy_c7", busy4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter N_INPUTS, default 8, number of x/w pairs per forward pass (power of two, 2..16).
REQ-002 Parameter LOSS_LAT, default 2, cycles allowed for the downstream loss stage after launch (>=1).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  request one forward pass; sampled only in IDLE.
REQ-006 target_i  input  4  training target; captured when start is accepted.
REQ-007 x_i  input  10  unsigned activation at the index on addr_o, valid in the same cycle.
REQ-008 w_i  input  8  unsigned weight (1.7 form) at the index on addr_o, valid in the same cycle.
REQ-009 addr_o  output  clog2(N_INPUTS)  x/w select index.
REQ-010 busy_o  output  1  high in every non-IDLE state.
REQ-011 final_o  output  23  last completed dot product, zero-extended.
REQ-012 target_o  output  4  target captured for the current or last pass.
REQ-013 loss_en_o  output  1  one-cycle launch pulse for the loss stage.
REQ-014 done_o  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have four states: IDLE, MAC, LOSS, DONE.
REQ-016 IDLE with start_i=1 SHALL go to MAC at the next edge, clear the accumulator and index, and capture target_i into target_o.
REQ-017 start_i SHALL be ignored in MAC, LOSS and DONE, including during the DONE cycle; it is neither queued nor counted.
REQ-018 In MAC, addr_o SHALL equal the index, which steps 0..N_INPUTS-1, one value per cycle.
REQ-019 In each MAC cycle, the accumulator SHALL take accumulator + x_i*w_i as a full-precision unsigned product and sum, with no truncation or saturation.
REQ-020 The accumulator SHALL be at least 21 bits wide (max 1023*255*8 = 2,086,920).
REQ-021 In the MAC cycle with index = N_INPUTS-1, the next edge SHALL load the complete sum into final_o and move the FSM to LOSS.
REQ-022 final_o SHALL hold its previous value throughout MAC; it is never partially updated.
REQ-023 loss_en_o SHALL be high only in the first LOSS cycle.
REQ-024 LOSS SHALL last exactly LOSS_LAT cycles, counted by an internal counter, then go to DONE.
REQ-025 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-026 Latency: with start_i sampled at edge 0, cycles are numbered so that cycle k follows edge k.
  - MAC: cycles 1..N_INPUTS.
  - loss_en_o: cycle N_INPUTS+1.
  - done_o: cycle N_INPUTS+1+LOSS_LAT (11 with defaults).
  - Next start can be accepted: start sampled in cycle N_INPUTS+2+LOSS_LAT (12 with defaults), since IDLE begins in that cycle.
REQ-027 addr_o SHALL read 0 outside MAC.
REQ-028 loss_en_o and done_o SHALL never be high in the same cycle.

Reset
REQ-029 rst_i=1 SHALL override all other inputs at the edge, in any state including mid-MAC or mid-LOSS.
REQ-030 After reset:
  - state = IDLE;
  - accumulator, index and loss counter = 0;
  - final_o = 0, target_o = 0, addr_o = 0;
  - busy_o, loss_en_o and done_o = 0.
REQ-031 A pass interrupted by reset SHALL produce no done_o or loss_en_o, and final_o SHALL read 0 afterwards.
REQ-032 start_i held high during the reset edge SHALL NOT start a pass; the first start is sampled at the edge after rst_i falls.

Verification
REQ-033 Basic pass: x=k+1 and w=2 at index k, start pulse, target_i=5 -> final_o=72 from cycle 9, loss_en_o in cycle 9, done_o in cycle 11, target_o=5.
REQ-034 Max operands: all x=1023 and w=255 -> final_o=2,086,920 with no wrap.
REQ-035 Held start: start_i held high continuously -> back-to-back passes with done_o every 12 cycles; no start is accepted in the DONE cycle.
REQ-036 Mid-pass reset: rst_i asserted in cycle 5 -> busy_o=0 and final_o=0 next cycle; no loss_en_o or done_o follows.
REQ-037 Hold behaviour: a second pass with all w=0 after a pass giving 72 -> final_o stays 72 through MAC, then becomes 0 in cycle 9.
REQ-038 Latency parameter: LOSS_LAT=1, N_INPUTS=4 -> loss_en_o in cycle 5, done_o in cycle 6, addr_o sequence 0,1,2,3.
